// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one DDR user port among 4 requesters, one command in flight,
// with an in-order read-tag FIFO for routing return data. Optional watchdog: DDR_ARB_TIMEOUT_EN.
module ddr_port_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int RD_DEPTH = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic                   i_ddr_clk,
  input  logic                   i_rst,
  input  logic [NUM_REQ-1:0]     i_req_wr,
  input  logic [NUM_REQ-1:0]     i_req_rd,
  input  logic [NUM_REQ*27-1:0]  i_req_addr,
  input  logic [NUM_REQ*256-1:0] i_req_wr_data,
  input  logic [NUM_REQ*32-1:0]  i_req_be_n,
  output logic [NUM_REQ-1:0]     o_req_ack,
  output logic [255:0]           o_rd_data,
  output logic [NUM_REQ-1:0]     o_rd_data_valid,
  output logic [255:0]           o_ddr_wr_data,
  output logic [31:0]            o_ddr_wr_data_be_n,
  output logic                   o_ddr_wr_data_valid,
  output logic [26:0]            o_ddr_addr,
  output logic                   o_ddr_rd,
  input  logic [255:0]           i_ddr_rd_data,
  input  logic                   i_ddr_rd_data_valid,
  input  logic                   i_ddr_wr_ack,
  input  logic                   i_ddr_rd_ack,
  output logic                   o_err,
  output logic [1:0]             o_fsm_state
);

  // Handshake: a requester holds i_req_wr/i_req_rd (with its addr/data/be_n) until it sees
  // o_req_ack; DDR-side command outputs stay stable while valid until i_ddr_wr_ack/i_ddr_rd_ack.

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WR_WAIT = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;

  localparam int AW = $clog2(RD_DEPTH);
  localparam logic [AW:0]        DEPTH_V = (AW+1)'(RD_DEPTH);
  localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);

  logic [1:0]    state;
  logic [1:0]    last_grant;
  logic [1:0]    grant;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic [1:0]    tag_mem [RD_DEPTH];

  logic [NUM_REQ-1:0] rd_ok;
  logic [NUM_REQ-1:0] elig;
  logic [1:0]    cand;
  logic [1:0]    win_idx;
  logic          win_found;
  logic          win_is_wr;
  logic          tag_push;
  logic          tag_pop;
  logic          rd_unexpected;
  logic          tmo_hit;
  logic          tmo_fire;

  assign o_fsm_state = state;

  // The ack mask stops a requester still holding its request during the ack cycle from
  // being granted a second time for the same command.
  assign rd_ok = i_req_rd & {NUM_REQ{occ < DEPTH_V}};
  assign elig  = (i_req_wr | rd_ok) & ~o_req_ack;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_is_wr     = i_req_wr[win_idx];
  assign tag_push      = (state == ST_IDLE) && win_found && !win_is_wr;
  assign tag_pop       = i_ddr_rd_data_valid && (occ != '0);
  assign rd_unexpected = i_ddr_rd_data_valid && (occ == '0);

`ifdef DDR_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge i_ddr_clk) begin
    if (i_rst) begin
      tmo_cnt <= '0;
    end else if ((state == ST_WR_WAIT && !i_ddr_wr_ack && !tmo_hit) ||
                 (state == ST_RD_WAIT && !i_ddr_rd_ack && !tmo_hit)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign tmo_fire = tmo_hit && ((state == ST_WR_WAIT && !i_ddr_wr_ack) ||
                                (state == ST_RD_WAIT && !i_ddr_rd_ack));

  always_ff @(posedge i_ddr_clk) begin
    if (i_rst) begin
      state               <= ST_IDLE;
      last_grant          <= '0;
      grant               <= '0;
      o_req_ack           <= '0;
      o_ddr_wr_data       <= '0;
      o_ddr_wr_data_be_n  <= '0;
      o_ddr_wr_data_valid <= 1'b0;
      o_ddr_addr          <= '0;
      o_ddr_rd            <= 1'b0;
    end else begin
      o_req_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            last_grant <= win_idx;
            grant      <= win_idx;
            o_ddr_addr <= i_req_addr[int'(win_idx)*27 +: 27];
            if (win_is_wr) begin
              o_ddr_wr_data       <= i_req_wr_data[int'(win_idx)*256 +: 256];
              o_ddr_wr_data_be_n  <= i_req_be_n[int'(win_idx)*32 +: 32];
              o_ddr_wr_data_valid <= 1'b1;
              state               <= ST_WR_WAIT;
            end else begin
              o_ddr_rd <= 1'b1;
              state    <= ST_RD_WAIT;
            end
          end
        end
        ST_WR_WAIT: begin
          if (i_ddr_wr_ack || tmo_fire) begin
            o_ddr_wr_data_valid <= 1'b0;
            o_req_ack           <= ONE << grant;
            state               <= ST_IDLE;
          end
        end
        ST_RD_WAIT: begin
          // A timed-out read keeps its tag: its data may still come back later.
          if (i_ddr_rd_ack || tmo_fire) begin
            o_ddr_rd  <= 1'b0;
            o_req_ack <= ONE << grant;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_ddr_clk) begin
    if (tag_push) tag_mem[wr_ptr] <= win_idx;
  end

  always_ff @(posedge i_ddr_clk) begin
    if (i_rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      occ             <= '0;
      o_rd_data       <= '0;
      o_rd_data_valid <= '0;
      o_err           <= 1'b0;
    end else begin
      o_rd_data_valid <= '0;
      if (tag_push) wr_ptr <= wr_ptr + 1'b1;
      if (tag_pop) begin
        rd_ptr          <= rd_ptr + 1'b1;
        o_rd_data       <= i_ddr_rd_data;
        o_rd_data_valid <= ONE << tag_mem[rd_ptr];
      end
      case ({tag_push, tag_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (rd_unexpected || tmo_fire) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Self-checking bench for ddr_port_arbiter: cycle vector table plus directed corner sequences.
module tb_ddr_port_arbiter;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req_wr, req_rd;
  logic [107:0]   req_addr;
  logic [1023:0]  req_wr_data;
  logic [127:0]   req_be_n;
  logic [3:0]     req_ack;
  logic [255:0]   rd_data;
  logic [3:0]     rd_data_valid;
  logic [255:0]   ddr_wr_data;
  logic [31:0]    ddr_wr_data_be_n;
  logic           ddr_wr_data_valid;
  logic [26:0]    ddr_addr;
  logic           ddr_rd;
  logic [255:0]   ddr_rd_data;
  logic           ddr_rd_data_valid;
  logic           ddr_wr_ack, ddr_rd_ack;
  logic           err;
  logic [1:0]     fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ddr_port_arbiter #(.RD_DEPTH(16), .TIMEOUT(8)) dut (
    .i_ddr_clk(clk), .i_rst(rst),
    .i_req_wr(req_wr), .i_req_rd(req_rd), .i_req_addr(req_addr),
    .i_req_wr_data(req_wr_data), .i_req_be_n(req_be_n),
    .o_req_ack(req_ack), .o_rd_data(rd_data), .o_rd_data_valid(rd_data_valid),
    .o_ddr_wr_data(ddr_wr_data), .o_ddr_wr_data_be_n(ddr_wr_data_be_n),
    .o_ddr_wr_data_valid(ddr_wr_data_valid), .o_ddr_addr(ddr_addr), .o_ddr_rd(ddr_rd),
    .i_ddr_rd_data(ddr_rd_data), .i_ddr_rd_data_valid(ddr_rd_data_valid),
    .i_ddr_wr_ack(ddr_wr_ack), .i_ddr_rd_ack(ddr_rd_ack),
    .o_err(err), .o_fsm_state(fsm_state)
  );

  typedef struct {
    logic [3:0] wr;
    logic [3:0] rd;
    logic       wack;
    logic       rack;
    logic       dv_in;
    logic [7:0] din;
    logic [3:0] e_ack;
    logic       e_wv;
    logic       e_rdc;
    logic [1:0] e_g;
    logic [3:0] e_dv;
    logic [7:0] e_dout;
    logic       e_err;
  } vec_t;

  vec_t tbl [21];

  function automatic logic [26:0] addr_of(input int n);
    return 27'h0000100 + 27'(n) * 27'h1000;
  endfunction

  function automatic logic [255:0] data_of(input int n);
    logic [7:0] b;
    b = 8'hA5 + 8'(n);
    return {32{b}};
  endfunction

  function automatic logic [31:0] be_of(input int n);
    logic [3:0] nib;
    nib = 4'(n);
    return {8{nib}};
  endfunction

  function automatic vec_t mk(input logic [3:0] wr, rd, input logic wack, rack, dv_in,
                              input logic [7:0] din, input logic [3:0] e_ack,
                              input logic e_wv, e_rdc, input logic [1:0] e_g,
                              input logic [3:0] e_dv, input logic [7:0] e_dout,
                              input logic e_err);
    vec_t v;
    v.wr = wr; v.rd = rd; v.wack = wack; v.rack = rack; v.dv_in = dv_in; v.din = din;
    v.e_ack = e_ack; v.e_wv = e_wv; v.e_rdc = e_rdc; v.e_g = e_g; v.e_dv = e_dv;
    v.e_dout = e_dout; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_wr = '0; req_rd = '0;
    ddr_wr_ack = 1'b0; ddr_rd_ack = 1'b0;
    ddr_rd_data_valid = 1'b0; ddr_rd_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   256'(req_ack), 0);
    check({tag, "_wv"},    256'(ddr_wr_data_valid), 0);
    check({tag, "_rdc"},   256'(ddr_rd), 0);
    check({tag, "_addr"},  256'(ddr_addr), 0);
    check({tag, "_wdata"}, ddr_wr_data, 0);
    check({tag, "_be"},    256'(ddr_wr_data_be_n), 0);
    check({tag, "_dv"},    256'(rd_data_valid), 0);
    check({tag, "_dout"},  rd_data, 0);
    check({tag, "_err"},   256'(err), 0);
  endtask

  initial begin
    int cnt;
    int acks;
    logic seen;

    for (int n = 0; n < 4; n++) begin
      req_addr[n*27 +: 27]     = addr_of(n);
      req_wr_data[n*256 +: 256] = data_of(n);
      req_be_n[n*32 +: 32]     = be_of(n);
    end

    //          wr     rd     wa rk dv din    ack    wv rdc g  dv     dout   err
    tbl[0]  = mk(4'h1, 4'h0, 0, 0, 0, 8'h00, 4'h0, 1, 0, 0, 4'h0, 8'h00, 0);
    tbl[1]  = mk(4'h1, 4'h0, 0, 0, 0, 8'h00, 4'h0, 1, 0, 0, 4'h0, 8'h00, 0);
    tbl[2]  = mk(4'h1, 4'h0, 1, 0, 0, 8'h00, 4'h1, 0, 0, 0, 4'h0, 8'h00, 0);
    tbl[3]  = mk(4'h1, 4'h0, 0, 0, 0, 8'h00, 4'h0, 0, 0, 0, 4'h0, 8'h00, 0);
    tbl[4]  = mk(4'h0, 4'h0, 1, 1, 0, 8'h00, 4'h0, 0, 0, 0, 4'h0, 8'h00, 0);
    tbl[5]  = mk(4'h0, 4'hF, 0, 0, 0, 8'h00, 4'h0, 0, 1, 1, 4'h0, 8'h00, 0);
    tbl[6]  = mk(4'h0, 4'hF, 0, 1, 0, 8'h00, 4'h2, 0, 0, 0, 4'h0, 8'h00, 0);
    tbl[7]  = mk(4'h0, 4'hF, 0, 0, 0, 8'h00, 4'h0, 0, 1, 2, 4'h0, 8'h00, 0);
    tbl[8]  = mk(4'h0, 4'hF, 0, 1, 0, 8'h00, 4'h4, 0, 0, 0, 4'h0, 8'h00, 0);
    tbl[9]  = mk(4'h0, 4'hF, 0, 0, 0, 8'h00, 4'h0, 0, 1, 3, 4'h0, 8'h00, 0);
    tbl[10] = mk(4'h0, 4'hF, 0, 1, 0, 8'h00, 4'h8, 0, 0, 0, 4'h0, 8'h00, 0);
    tbl[11] = mk(4'h0, 4'hF, 0, 0, 0, 8'h00, 4'h0, 0, 1, 0, 4'h0, 8'h00, 0);
    tbl[12] = mk(4'h0, 4'hF, 0, 1, 0, 8'h00, 4'h1, 0, 0, 0, 4'h0, 8'h00, 0);
    tbl[13] = mk(4'h0, 4'h0, 0, 0, 0, 8'h00, 4'h0, 0, 0, 0, 4'h0, 8'h00, 0);
    tbl[14] = mk(4'h0, 4'h0, 0, 0, 1, 8'hAA, 4'h0, 0, 0, 0, 4'h2, 8'hAA, 0);
    tbl[15] = mk(4'h0, 4'h0, 0, 0, 1, 8'hBB, 4'h0, 0, 0, 0, 4'h4, 8'hBB, 0);
    tbl[16] = mk(4'h0, 4'h0, 0, 0, 0, 8'h00, 4'h0, 0, 0, 0, 4'h0, 8'hBB, 0);
    tbl[17] = mk(4'h0, 4'h0, 0, 0, 1, 8'hCC, 4'h0, 0, 0, 0, 4'h8, 8'hCC, 0);
    tbl[18] = mk(4'h0, 4'h0, 0, 0, 1, 8'hDD, 4'h0, 0, 0, 0, 4'h1, 8'hDD, 0);
    tbl[19] = mk(4'h0, 4'h0, 0, 0, 1, 8'hEE, 4'h0, 0, 0, 0, 4'h0, 8'hDD, 1);
    tbl[20] = mk(4'h0, 4'h0, 0, 0, 0, 8'h00, 4'h0, 0, 0, 0, 4'h0, 8'hDD, 1);

    do_reset();
    check_all_zero("reset");

    for (int i = 0; i < 21; i++) begin
      req_wr = tbl[i].wr;
      req_rd = tbl[i].rd;
      ddr_wr_ack = tbl[i].wack;
      ddr_rd_ack = tbl[i].rack;
      ddr_rd_data_valid = tbl[i].dv_in;
      ddr_rd_data = {32{tbl[i].din}};
      step();
      check($sformatf("v%0d_ack", i), 256'(req_ack), 256'(tbl[i].e_ack));
      check($sformatf("v%0d_wv", i), 256'(ddr_wr_data_valid), 256'(tbl[i].e_wv));
      check($sformatf("v%0d_rdc", i), 256'(ddr_rd), 256'(tbl[i].e_rdc));
      check($sformatf("v%0d_dv", i), 256'(rd_data_valid), 256'(tbl[i].e_dv));
      check($sformatf("v%0d_dout", i), rd_data, {32{tbl[i].e_dout}});
      check($sformatf("v%0d_err", i), 256'(err), 256'(tbl[i].e_err));
      if (tbl[i].e_wv || tbl[i].e_rdc)
        check($sformatf("v%0d_addr", i), 256'(ddr_addr), 256'(addr_of(int'(tbl[i].e_g))));
      if (tbl[i].e_wv) begin
        check($sformatf("v%0d_wdata", i), ddr_wr_data, data_of(int'(tbl[i].e_g)));
        check($sformatf("v%0d_be", i), 256'(ddr_wr_data_be_n), 256'(be_of(int'(tbl[i].e_g))));
      end
    end

    // Read FIFO fills at 16 outstanding; a write must still get through.
    do_reset();
    req_rd = 4'b0100;
    ddr_rd_ack = 1'b1;
    ddr_wr_ack = 1'b1;
    cnt = 0;
    for (int c = 0; c < 120; c++) begin
      step();
      if (req_ack[2]) cnt++;
    end
    check("rd_issue_cap", 256'(cnt), 256'(16));
    check("rd_stalled", 256'(ddr_rd), 0);
    req_wr = 4'b0010;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (ddr_wr_data_valid) check("full_wr_addr", 256'(ddr_addr), 256'(addr_of(1)));
      if (req_ack[1]) seen = 1'b1;
    end
    check("full_wr_acked", 256'(seen), 1);
    req_wr = '0;
    req_rd = '0;
    for (int i = 0; i < 16; i++) begin
      ddr_rd_data_valid = 1'b1;
      ddr_rd_data = {32{8'(i + 1)}};
      step();
      check($sformatf("drain%0d_dv", i), 256'(rd_data_valid), 256'(4'b0100));
      check($sformatf("drain%0d_dout", i), rd_data, {32{8'(i + 1)}});
    end
    ddr_rd_data_valid = 1'b0;
    step();
    check("drain_no_err", 256'(err), 0);
    check("drain_dv_clear", 256'(rd_data_valid), 0);

    // Write and read from the same requester: write first.
    do_reset();
    req_wr = 4'b1000;
    req_rd = 4'b1000;
    ddr_wr_ack = 1'b1;
    ddr_rd_ack = 1'b1;
    step();
    check("wr_first_wv", 256'(ddr_wr_data_valid), 1);
    check("wr_first_rdc", 256'(ddr_rd), 0);
    check("wr_first_addr", 256'(ddr_addr), 256'(addr_of(3)));
    step();
    check("wr_first_ack", 256'(req_ack), 256'(4'b1000));
    req_wr = '0;
    step();
    check("wr_first_gap", 256'(ddr_rd), 0);
    step();
    check("rd_second_rdc", 256'(ddr_rd), 1);
    check("rd_second_wv", 256'(ddr_wr_data_valid), 0);
    step();
    check("rd_second_ack", 256'(req_ack), 256'(4'b1000));
    req_rd = '0;

    // Reset while a read waits for its ack with 3 reads outstanding.
    do_reset();
    req_rd = 4'b0111;
    ddr_rd_ack = 1'b1;
    acks = 0;
    for (int c = 0; c < 20 && acks < 2; c++) begin
      step();
      if (|req_ack) acks++;
    end
    check("rst_setup_acks", 256'(acks), 2);
    ddr_rd_ack = 1'b0;
    step();
    check("rst_setup_rdc", 256'(ddr_rd), 1);
    step();
    check("rst_setup_hold", 256'(ddr_rd), 1);
    rst = 1'b1;
    req_rd = '0;
    step();
    check_all_zero("midrst");
    rst = 1'b0;
    step();
    ddr_rd_data_valid = 1'b1;
    ddr_rd_data = {32{8'h5A}};
    step();
    ddr_rd_data_valid = 1'b0;
    check("midrst_drop_dv", 256'(rd_data_valid), 0);
    check("midrst_err", 256'(err), 1);

`ifdef DDR_ARB_TIMEOUT_EN
    do_reset();
    req_wr = 4'b0001;
    cnt = 0;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      step();
      if (ddr_wr_data_valid) cnt++;
      else if (cnt > 0) begin
        seen = 1'b1;
        check("tmo_ack", 256'(req_ack), 256'(4'b0001));
        check("tmo_err", 256'(err), 1);
      end
    end
    check("tmo_seen", 256'(seen), 1);
    check("tmo_len", 256'(cnt), 256'(8));
    req_wr = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
